// File: rtl/rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the round-robin mux arbiter slice.
//   - arb_state_t  : arbiter FSM states (IDLE, GRANT)
//   - *_DEF        : default requester count, select width and hold limit
//   - hold_width() : width needed for a hold counter counting 0..max_hold-1
// Optional feature macro used by this slice: ARB_LOCK_EN (see rr_mux_arbiter).
// ----------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int N_REQ_DEF    = 16;
    localparam int SEL_W_DEF    = 4;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // A hold limit of 1 still needs a one-bit counter so the compare is legal.
    function automatic int hold_width(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-and-priority-encode. Scans req starting at ptr,
// then ptr+1, ... wrapping modulo N_REQ, and reports the first set bit.
// When mask_en is high the request at mask_idx is ignored.
// Ports:
//   req      in  N_REQ  request vector
//   ptr      in  SEL_W  scan start position
//   mask_en  in  1      enable exclusion of mask_idx
//   mask_idx in  SEL_W  index to exclude from the scan
//   found    out 1      some eligible request exists
//   idx      out SEL_W  index of the first eligible request
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 16,
    parameter int SEL_W = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mask_en,
    input  logic [SEL_W-1:0] mask_idx,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] pos;

    // Walk the rotated order from the far end back to the start so that
    // the nearest eligible request (smallest offset from ptr) is the one
    // left standing. N_REQ is a power of two, so the SEL_W-bit add wraps
    // exactly modulo N_REQ.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (req[pos] && !(mask_en && (pos == mask_idx))) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin scheduler for an N:1 select datapath. Arbitrates req, drives a
// registered one-hot grant and binary sel, limits how long one owner may
// hold the grant, and registers the selected data bit.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous reset, active-high
//   req        in  N_REQ  level request per source, held until served
//   in         in  N_REQ  data bit per source
//   lock       in  1      present only when ARB_LOCK_EN is defined
//   grant      out N_REQ  one-hot grant, registered
//   sel        out SEL_W  binary index of current owner, registered
//   gnt_valid  out 1      grant/sel meaningful this cycle
//   out        out 1      registered in[sel], one cycle after gnt_valid
// Build option: ARB_LOCK_EN adds the lock input; while lock is high in GRANT
// the hold timeout is suppressed and the owner leaves only by dropping req.
// ----------------------------------------------------------------------------
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int SEL_W    = SEL_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] in,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid,
    output logic             out
);

    localparam int HOLD_W = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT0  = N_REQ'(1);

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             valid_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    logic             lock_active;
    logic             release_now;
    logic [SEL_W-1:0] pick_ptr;
    logic             pick_mask_en;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

`ifdef ARB_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    // In IDLE the scan starts at the stored pointer. In GRANT the scan is the
    // one used on release: start just past the current owner and skip it, so
    // the pointer update and the pick agree within the same cycle.
    assign pick_mask_en = (state == GRANT);
    assign pick_ptr     = (state == GRANT) ? SEL_W'(sel + 1'b1) : ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask_en  (pick_mask_en),
        .mask_idx (sel),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // The owner lets go when it drops its request or, unless locked, when it
    // has used its full hold allowance.
    assign release_now = !req[sel] || ((hold_cnt == HOLD_LAST) && !lock_active);

    // Next-state logic. A release with another requester waiting hands the
    // grant over directly with no idle bubble; a timed-out owner that is the
    // only requester simply restarts its allowance.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        valid_nxt = gnt_valid;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    grant_nxt = ONE_HOT0 << pick_idx;
                    sel_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_nxt  = SEL_W'(sel + 1'b1);
                    hold_nxt = '0;
                    if (pick_found) begin
                        grant_nxt = ONE_HOT0 << pick_idx;
                        sel_nxt   = pick_idx;
                    end else if (!req[sel]) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        valid_nxt = 1'b0;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Arbiter state registers; reset drops the grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            sel       <= sel_nxt;
            gnt_valid <= valid_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

    // Data path: capture the currently selected bit, so out trails sel by
    // one cycle and reads zero whenever no grant was valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= gnt_valid ? in[sel] : 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Directed bench for rr_mux_arbiter at the default configuration
// (16 requesters, hold limit 8). A table of per-cycle vectors covers the
// basic grant/release/data path, followed by hand-written sequences for
// full round-robin rotation, pointer wrap, early release, reset during a
// grant and, when ARB_LOCK_EN is defined, the lock behaviour.
// ----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    typedef struct {
        logic [15:0] req;
        logic [15:0] din;
        logic [15:0] exp_grant;
        logic [3:0]  exp_sel;
        logic        exp_valid;
        logic        exp_out;
        bit          chk_sel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] din;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        gnt_valid;
    logic        dout;
`ifdef ARB_LOCK_EN
    logic        lock;
`endif

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs[9];

    always #5 clk = ~clk;

    rr_mux_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in        (din),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .out       (dout)
    );

    // Advance one clock and settle just after the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new input pair and let one clock edge consume it.
    task automatic applyStimulus(input logic [15:0] r, input logic [15:0] d);
        req = r;
        din = d;
        tick();
    endtask

    // Compare DUT outputs against expected values; sel is only meaningful
    // while a grant is valid or straight out of reset.
    task automatic checkOutput(input string name, input logic [15:0] eg,
                               input logic [3:0] es, input logic ev,
                               input logic eo, input bit cs);
        n_vec++;
        if (grant !== eg || gnt_valid !== ev || dout !== eo || (cs && sel !== es)) begin
            n_err++;
            $display("[TB] FAIL %s: got grant=%h sel=%0d valid=%b out=%b, expected grant=%h sel=%0d valid=%b out=%b",
                     name, grant, sel, gnt_valid, dout, eg, es, ev, eo);
        end
    endtask

    // Hold reset over two edges and release it away from the active edge.
    task automatic doReset();
        rst = 1'b1;
        req = '0;
        din = '0;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] rr_din;
        logic        prev_v;
        logic [3:0]  prev_s;
        logic        exp_o;

        //             req      din      grant    sel  v     out   chk_sel
        vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h0008, 16'h0008, 16'h0008, 4'd3, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h0008, 16'h0008, 16'h0008, 4'd3, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{16'h0008, 16'h0000, 16'h0008, 4'd3, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 16'h0008, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h0021, 16'h0001, 16'h0020, 4'd5, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h0001, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        req = '0;
        din = '0;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);

        // Basic grant, hold, release to idle, pointer-based pick, handover.
        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].req, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_sel,
                        vecs[i].exp_valid, vecs[i].exp_out, vecs[i].chk_sel);
        end

        // All requesting: owners 0..15 then 0 again, 8 cycles each.
        doReset();
        rr_din = 16'hA5C3;
        prev_v = 1'b0;
        prev_s = 4'd0;
        for (int o = 0; o < 17; o++) begin
            for (int c = 0; c < 8; c++) begin
                applyStimulus(16'hFFFF, rr_din);
                exp_o = prev_v ? rr_din[prev_s] : 1'b0;
                checkOutput($sformatf("rr_owner%0d_cyc%0d", o % 16, c),
                            16'(1) << (o % 16), 4'(o % 16), 1'b1, exp_o, 1'b1);
                prev_v = 1'b1;
                prev_s = 4'(o % 16);
            end
        end

        // Owner 15 times out and the grant wraps to requester 0 with no gap.
        doReset();
        applyStimulus(16'h8000, 16'h0000);
        checkOutput("wrap_first", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b1);
        for (int c = 1; c < 8; c++) begin
            applyStimulus(16'h8001, 16'h0000);
            checkOutput($sformatf("wrap_hold%0d", c), 16'h8000, 4'd15, 1'b1, 1'b0, 1'b1);
        end
        applyStimulus(16'h8001, 16'h0000);
        checkOutput("wrap_to0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1);

        // Owner 2 drops after 3 cycles; requester 5 takes over next cycle,
        // then as sole requester is re-granted across its timeout.
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(16'h0004, 16'h0000);
            checkOutput($sformatf("early_own2_%0d", c), 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
        end
        applyStimulus(16'h0020, 16'h0000);
        checkOutput("early_to5", 16'h0020, 4'd5, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(16'h0020, 16'h0000);
            checkOutput($sformatf("regrant5_%0d", c), 16'h0020, 4'd5, 1'b1, 1'b0, 1'b1);
        end

        // Reset asserted mid-grant clears everything without waiting for a clock.
        doReset();
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(16'h0004, 16'h0004);
            checkOutput($sformatf("pre_rst%0d", c), 16'h0004, 4'd2, 1'b1, (c > 1), 1'b1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_midgrant", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);

`ifdef ARB_LOCK_EN
        // Locked owner 0 outlasts its allowance; unlocking hands over to 1.
        doReset();
        lock = 1'b1;
        for (int c = 0; c < 21; c++) begin
            applyStimulus(16'h0003, 16'h0000);
            checkOutput($sformatf("lock_own0_%0d", c), 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1);
        end
        lock = 1'b0;
        applyStimulus(16'h0003, 16'h0000);
        checkOutput("unlock_to1", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0000, 16'h0000);
        checkOutput("lock_idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
